// File: rtl/memlcd_frame_scheduler.sv
// Frame/line sequencer and VCOM polarity generator for the memory-LCD driver path.
// Optional build macro VCOM_SYNC_EN: defer VCOM phase toggles out of the active scan.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | scheduler parked, no frame in progress
// WAIT_DATA | waiting for a buffered line and the minimum frame period
// START     | one-cycle frame start pulse, line address cleared
// LINE      | requesting the driver to shift out the current line
// FILL      | waiting for the next line to land in the FIFO
// GAP       | frame finished or abandoned, decide whether to continue
module memlcd_frame_scheduler #(
   parameter int LINES            = 240,
   parameter int MIN_FRAME_CYCLES = 1_666_666,
   parameter int VCOM_HALF        = 50_000_000,
   parameter int LINE_TIMEOUT     = 4096
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_enable,
   input  logic                     i_vcom_start,
   input  logic                     i_wfull,
   input  logic                     i_wfull_almost,
   input  logic                     i_rempty,
   input  logic                     i_rempty_almost,
   input  logic                     i_line_done,
   output logic                     o_frame_start,
   output logic                     o_line_req,
   output logic [$clog2(LINES)-1:0] o_line_addr,
   output logic                     o_spi_cts,
   output logic                     o_va,
   output logic                     o_vb,
   output logic                     o_vcom,
   output logic                     o_busy,
   output logic                     o_underrun,
   output logic [7:0]               o_frame_cnt
);

   localparam int AW = $clog2(LINES);
   localparam int PW = $clog2(MIN_FRAME_CYCLES + 1);
   localparam int VW = (VCOM_HALF > 1) ? $clog2(VCOM_HALF) : 1;
   localparam int TW = (LINE_TIMEOUT > 1) ? $clog2(LINE_TIMEOUT) : 1;

   localparam logic [AW-1:0] LAST_LINE  = AW'(LINES - 1);
   localparam logic [PW-1:0] PERIOD_MAX = PW'(MIN_FRAME_CYCLES);
   localparam logic [PW-1:0] PERIOD_OK  = PW'(MIN_FRAME_CYCLES - 1);
   localparam logic [VW-1:0] VCOM_LAST  = VW'(VCOM_HALF - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(LINE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_DATA,
      START,
      LINE,
      FILL,
      GAP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   period_cnt;
   logic [TW-1:0]   timeout_cnt;
   logic [AW-1:0]   line_addr;
   logic [7:0]      frame_cnt;
   logic [VW-1:0]   vcom_cnt;
   logic            vcom_phase;
   logic            vcom_phase_nxt;
   logic            vcom_due;
   logic            vcom_toggle;
   logic            vb_q;
   logic            frame_start_q;
   logic            line_req_q;
   logic            busy_q;
   logic            underrun_q;
   logic            cts_q;
   logic            period_ok;
   logic            last_line;
   logic            frame_done;
   logic            line_adv;
   logic            underrun_hit;

   // Read-side empty is implied by almost-empty, so it never steers the FSM.
   logic unused_rempty;
   assign unused_rempty = i_rempty;

   // A new frame may launch on the edge that completes MIN_FRAME_CYCLES clocks
   // since the previous pulse, giving an exact period when data is always ready.
   assign period_ok    = (period_cnt >= PERIOD_OK);
   assign last_line    = (line_addr == LAST_LINE);
   assign frame_done   = (state == LINE) && i_line_done && last_line;
   assign line_adv     = (state == LINE) && i_line_done && !last_line;
   assign underrun_hit = (state == FILL) && i_rempty_almost && (timeout_cnt == TO_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_enable) state_nxt = WAIT_DATA;
         end
         WAIT_DATA: begin
            if (!i_enable)                          state_nxt = IDLE;
            else if (!i_rempty_almost && period_ok) state_nxt = START;
         end
         START: begin
            state_nxt = LINE;
         end
         LINE: begin
            if (i_line_done) state_nxt = last_line ? GAP : FILL;
         end
         FILL: begin
            if (!i_rempty_almost)  state_nxt = LINE;
            else if (underrun_hit) state_nxt = GAP;
         end
         GAP: begin
            state_nxt = i_enable ? WAIT_DATA : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= IDLE;
         frame_start_q <= 1'b0;
         line_req_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state         <= state_nxt;
         frame_start_q <= (state_nxt == START);
         line_req_q    <= (state_nxt == LINE);
         busy_q        <= (state_nxt != IDLE);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         period_cnt <= PERIOD_MAX;
      end else if (state_nxt == START) begin
         period_cnt <= '0;
      end else if (period_cnt != PERIOD_MAX) begin
         period_cnt <= period_cnt + PW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         line_addr <= '0;
      end else if (state_nxt == START) begin
         line_addr <= '0;
      end else if (line_adv) begin
         line_addr <= line_addr + AW'(1);
      end
   end

   // Held at zero outside FILL so every FILL visit starts a fresh budget.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         timeout_cnt <= '0;
      end else if (state != FILL) begin
         timeout_cnt <= '0;
      end else if (timeout_cnt != TO_LAST) begin
         timeout_cnt <= timeout_cnt + TW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         frame_cnt  <= 8'd0;
         underrun_q <= 1'b0;
      end else begin
         if (frame_done) frame_cnt <= frame_cnt + 8'd1;
         if (!i_enable)         underrun_q <= 1'b0;
         else if (underrun_hit) underrun_q <= 1'b1;
      end
   end

   // Clear-to-send hysteresis: drop near full, re-arm only once the reader has drained.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cts_q <= 1'b0;
      end else if (i_wfull || i_wfull_almost) begin
         cts_q <= 1'b0;
      end else if (i_rempty_almost) begin
         cts_q <= 1'b1;
      end
   end

   assign vcom_due = i_vcom_start && (vcom_cnt == VCOM_LAST);

`ifdef VCOM_SYNC_EN
   logic vcom_pend;
   logic vcom_safe;

   assign vcom_safe   = (state == IDLE) || (state == WAIT_DATA) || (state == GAP);
   assign vcom_toggle = (vcom_due || vcom_pend) && vcom_safe;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vcom_pend <= 1'b0;
      end else if (!i_vcom_start || vcom_toggle) begin
         vcom_pend <= 1'b0;
      end else if (vcom_due) begin
         vcom_pend <= 1'b1;
      end
   end
`else
   assign vcom_toggle = vcom_due;
`endif

   assign vcom_phase_nxt = vcom_phase ^ vcom_toggle;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vcom_cnt   <= '0;
         vcom_phase <= 1'b0;
         vb_q       <= 1'b0;
      end else if (!i_vcom_start) begin
         vcom_cnt   <= '0;
         vcom_phase <= 1'b0;
         vb_q       <= 1'b0;
      end else begin
         vcom_cnt   <= (vcom_cnt == VCOM_LAST) ? '0 : vcom_cnt + VW'(1);
         vcom_phase <= vcom_phase_nxt;
         vb_q       <= ~vcom_phase_nxt;
      end
   end

   assign o_frame_start = frame_start_q;
   assign o_line_req    = line_req_q;
   assign o_line_addr   = line_addr;
   assign o_spi_cts     = cts_q;
   assign o_va          = vcom_phase;
   assign o_vb          = vb_q;
   assign o_vcom        = vcom_phase;
   assign o_busy        = busy_q;
   assign o_underrun    = underrun_q;
   assign o_frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_memlcd_frame_scheduler.sv
// Self-checking bench for memlcd_frame_scheduler (small parameter set).
module tb_memlcd_frame_scheduler;

   localparam int LINES  = 4;
   localparam int MIN_FC = 64;
   localparam int VHALF  = 16;
   localparam int LTO    = 8;

   logic       i_clk = 1'b0;
   logic       i_reset_n = 1'b0;
   logic       i_enable = 1'b0;
   logic       i_vcom_start = 1'b0;
   logic       i_wfull = 1'b0;
   logic       i_wfull_almost = 1'b0;
   logic       i_rempty = 1'b0;
   logic       i_rempty_almost = 1'b1;
   logic       i_line_done = 1'b0;
   logic       o_frame_start;
   logic       o_line_req;
   logic [1:0] o_line_addr;
   logic       o_spi_cts;
   logic       o_va;
   logic       o_vb;
   logic       o_vcom;
   logic       o_busy;
   logic       o_underrun;
   logic [7:0] o_frame_cnt;

   memlcd_frame_scheduler #(
      .LINES(LINES),
      .MIN_FRAME_CYCLES(MIN_FC),
      .VCOM_HALF(VHALF),
      .LINE_TIMEOUT(LTO)
   ) dut (
      .i_clk(i_clk),
      .i_reset_n(i_reset_n),
      .i_enable(i_enable),
      .i_vcom_start(i_vcom_start),
      .i_wfull(i_wfull),
      .i_wfull_almost(i_wfull_almost),
      .i_rempty(i_rempty),
      .i_rempty_almost(i_rempty_almost),
      .i_line_done(i_line_done),
      .o_frame_start(o_frame_start),
      .o_line_req(o_line_req),
      .o_line_addr(o_line_addr),
      .o_spi_cts(o_spi_cts),
      .o_va(o_va),
      .o_vb(o_vb),
      .o_vcom(o_vcom),
      .o_busy(o_busy),
      .o_underrun(o_underrun),
      .o_frame_cnt(o_frame_cnt)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int exp_addr_q[$];

   typedef struct {
      logic wf;
      logic wfa;
      logic rea;
      logic cts;
   } cts_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_frame_start"}, o_frame_start, 0);
      check({pfx, "_line_req"}, o_line_req, 0);
      check({pfx, "_line_addr"}, o_line_addr, 0);
      check({pfx, "_cts"}, o_spi_cts, 0);
      check({pfx, "_va_vb_vcom"}, {o_va, o_vb, o_vcom}, 0);
      check({pfx, "_busy"}, o_busy, 0);
      check({pfx, "_underrun"}, o_underrun, 0);
      check({pfx, "_frame_cnt"}, o_frame_cnt, 0);
   endtask

   task automatic wait_fs(input int bound, output bit found, output int at_cyc);
      found  = 1'b0;
      at_cyc = 0;
      for (int i = 0; i < bound && !found; i++) begin
         tick();
         if (o_frame_start) begin
            found  = 1'b1;
            at_cyc = cyc;
            for (int a = 0; a < LINES; a++) exp_addr_q.push_back(a);
         end
      end
   endtask

   task automatic serve_line(input bit expect_reassert);
      bit got;
      int e;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         if (o_line_req) got = 1'b1;
         else tick();
      end
      check("line_req_seen", got, 1);
      if (got) begin
         e = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : -1;
         check("line_addr", o_line_addr, e);
         i_line_done = 1'b1;
         tick();
         i_line_done = 1'b0;
         check("line_req_fall", o_line_req, 0);
         if (expect_reassert) begin
            tick();
            check("line_req_reassert", o_line_req, 1);
         end
      end
   endtask

   task automatic serve_frame();
      for (int l = 0; l < LINES; l++) serve_line(l != LINES - 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cts_vec_t cts_tbl[8];
      bit found;
      int t0, t1, t2, t3;
      int toggles[$];
      int bad_pairs;
      int ntog;
      logic prev, v0;

      cts_tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1};
      cts_tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
      cts_tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0};
      cts_tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1};
      cts_tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      cts_tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
      cts_tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0};
      cts_tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1};

      #12;
      check_reset_vals("reset");
      @(negedge i_clk);
      i_reset_n = 1'b1;
      tick();
      check("cts_after_reset", o_spi_cts, 1);

      foreach (cts_tbl[i]) begin
         i_wfull         = cts_tbl[i].wf;
         i_wfull_almost  = cts_tbl[i].wfa;
         i_rempty_almost = cts_tbl[i].rea;
         tick();
         check($sformatf("cts_vec%0d", i), o_spi_cts, cts_tbl[i].cts);
      end
      i_wfull        = 1'b0;
      i_wfull_almost = 1'b0;

      // first frame, then two back-to-back frames
      i_rempty_almost = 1'b0;
      i_enable        = 1'b1;
      wait_fs(2, found, t0);
      check("first_frame_latency", found, 1);
      serve_frame();
      check("frame_cnt_1", o_frame_cnt, 1);
      wait_fs(80, found, t1);
      check("frame2_seen", found, 1);
      check("frame_period_1", t1 - t0, MIN_FC);
      serve_frame();
      wait_fs(80, found, t2);
      check("frame3_seen", found, 1);
      check("frame_period_2", t2 - t1, MIN_FC);
      serve_frame();
      check("frame_cnt_3", o_frame_cnt, 3);

      // underrun after line 1
      wait_fs(80, found, t3);
      check("frame4_seen", found, 1);
      serve_line(1);
      i_rempty_almost = 1'b1;
      serve_line(0);
      for (int i = 0; i < LTO - 1; i++) tick();
      check("underrun_early", o_underrun, 0);
      check("fill_busy", o_busy, 1);
      tick();
      check("underrun_set", o_underrun, 1);
      check("underrun_frame_cnt", o_frame_cnt, 3);
      check("underrun_gap_busy", o_busy, 1);
      tick();
      check("underrun_sticky", o_underrun, 1);
      i_enable = 1'b0;
      tick();
      check("underrun_clear", o_underrun, 0);
      check("underrun_idle", o_busy, 0);
      exp_addr_q.delete();

      // enable dropped mid-frame still completes the frame
      i_rempty_almost = 1'b0;
      i_enable        = 1'b1;
      wait_fs(80, found, t0);
      check("frame5_seen", found, 1);
      serve_line(1);
      i_enable = 1'b0;
      serve_line(1);
      serve_line(1);
      serve_line(0);
      check("disable_gap_busy", o_busy, 1);
      check("frame_cnt_4", o_frame_cnt, 4);
      tick();
      check("disable_idle_busy", o_busy, 0);
      check("disable_idle_line_req", o_line_req, 0);

      // asynchronous reset in the middle of LINE
      i_enable = 1'b1;
      wait_fs(80, found, t0);
      check("frame6_seen", found, 1);
      tick();
      check("pre_reset_line_req", o_line_req, 1);
      #2;
      i_reset_n = 1'b0;
      #1;
      check_reset_vals("midline_rst");
      i_enable = 1'b0;
      exp_addr_q.delete();
      @(negedge i_clk);
      i_reset_n = 1'b1;
      tick();

      // free-running VCOM with the FSM idle
      i_vcom_start = 1'b1;
      tick();
      check("vcom_first", {o_va, o_vb, o_vcom}, 3'b010);
      prev      = o_vcom;
      bad_pairs = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (o_vcom !== prev) toggles.push_back(cyc);
         prev = o_vcom;
         if (o_vb !== ~o_va || o_vcom !== o_va) bad_pairs++;
      end
      check("vcom_toggle_count", toggles.size() >= 3, 1);
      if (toggles.size() >= 3) begin
         check("vcom_half_1", toggles[1] - toggles[0], VHALF);
         check("vcom_half_2", toggles[2] - toggles[1], VHALF);
      end
      check("vcom_vb_inverse", bad_pairs, 0);
      i_vcom_start = 1'b0;
      tick();
      check("vcom_off", {o_va, o_vb, o_vcom}, 0);

      // VCOM toggle falling due while a line is being requested
      i_vcom_start    = 1'b1;
      i_rempty_almost = 1'b0;
      i_enable        = 1'b1;
      wait_fs(80, found, t0);
      check("frame_vcom_seen", found, 1);
      tick();
      check("vcom_line_req", o_line_req, 1);
      v0   = o_vcom;
      prev = o_vcom;
      ntog = 0;
      for (int i = 0; i < 17; i++) begin
         tick();
         if (o_vcom !== prev) ntog++;
         prev = o_vcom;
      end
`ifdef VCOM_SYNC_EN
      check("vcom_held_in_line", ntog, 0);
      i_enable = 1'b0;
      serve_frame();
      tick();
      check("vcom_applied_in_gap", o_vcom, ~v0);
`else
      check("vcom_free_in_line", ntog > 0, 1);
      i_enable = 1'b0;
      serve_frame();
      tick();
`endif
      check("vcom_end_idle", o_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
